multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Moore-style control FSM that sequences the shared single-ALU MIPS datapath over multiple clock cycles per instruction, replacing single-cycle combinational control. It covers add, sub, and, or, slt, addi, lw, sw, beq, j and jal.
- Inputs: opcode/funct from the instruction register, the ALU zero flag, and a ready handshake from data memory.
- Outputs: register-write enables and mux selects for PC, IR, register file, ALU and data memory, plus debug/status signals.

## Interface
- DM_WAIT_MAX, default 15: maximum `dm_ready` wait cycles before the memory-timeout trap.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset: asynchronous, active-low.
- op  in  6  instruction[31:26], taken from the IR output.
- funct  in  6  instruction[5:0].
- zero  in  1  ALU zero flag.
- dm_ready  in  1  data memory has completed the current read or write.
- ir_wr  out  1  load IR from instruction memory.
- pc_wr  out  1  load PC.
- pc_src  out  2  PC source: 00 = PC+4, 01 = branch target (PC + sext(imm)<<2), 10 = {PC[31:28], imm26, 2'b00}.
- rf_wr  out  1  register-file write enable.
- reg_dst  out  2  destination register: 00 = rt, 01 = rd, 10 = $31.
- wd_sel  out  2  write-data source: 00 = ALU result register, 01 = MDR, 10 = PC.
- alu_srcb  out  1  ALU B operand: 0 = rt data, 1 = sign-extended imm16.
- alu_op  out  3  ALU operation: ADD=0, SUB=1, AND=2, OR=3, SLT=4.
- dm_rd, dm_wr  out  1 each  data-memory read and write strobes.
- instr_done  out  1  one-cycle pulse in the final cycle of each instruction.
- trap  out  1  sticky; set on an illegal opcode/funct or a memory timeout.
- state  out  4  current state, for debug.

## Operation
- States and encodings:
  - S_RST=0, FETCH=1, DECODE=2, EXE_R=3, EXE_I=4, MEM_ADR=5, MEM_RD=6, MEM_WB=7, MEM_WR=8, ALU_WB=9, BRANCH=10, JUMP=11, JAL=12, TRAP=15.
- Opcodes decoded:
  - R-type op=000000, with funct 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - addi 001000, lw 100011, sw 101011, beq 000100, j 000010, jal 000011.
- Transitions:
  - S_RST → FETCH.
  - FETCH → DECODE.
  - DECODE → EXE_R (R-type with a legal funct), EXE_I (addi), MEM_ADR (lw/sw), BRANCH, JUMP or JAL; any other op/funct → TRAP.
  - EXE_R → ALU_WB; EXE_I → ALU_WB.
  - MEM_ADR → MEM_RD (lw) or MEM_WR (sw).
  - MEM_RD → MEM_WB when dm_ready=1; MEM_WB → FETCH.
  - MEM_WR → FETCH when dm_ready=1.
  - ALU_WB, BRANCH, JUMP, JAL → FETCH.
  - TRAP → TRAP until reset.
- Outputs, per state (all other outputs 0):
  - FETCH: ir_wr=1, pc_wr=1, pc_src=00.
  - EXE_R: alu_op from funct.
  - EXE_I and MEM_ADR: alu_srcb=1, alu_op=ADD.
  - MEM_RD: dm_rd=1, held asserted until dm_ready.
  - MEM_WR: dm_wr=1, held asserted until dm_ready; instr_done is asserted in the dm_ready cycle.
  - MEM_WB: rf_wr=1, reg_dst=00, wd_sel=01, instr_done=1.
  - ALU_WB: rf_wr=1, wd_sel=00, reg_dst=01 for R-type or 00 for addi, instr_done=1.
  - BRANCH: alu_op=SUB, pc_wr=zero, pc_src=01, instr_done=1.
  - JUMP: pc_wr=1, pc_src=10, instr_done=1.
  - JAL: pc_wr=1, pc_src=10, rf_wr=1, reg_dst=10, wd_sel=10 (PC already equals the old PC+4), instr_done=1.
- The decoded instruction class is registered in DECODE and used in later states, so op/funct may change after DECODE.
- Wait counter:
  - 4-bit, cleared on entry to MEM_RD/MEM_WR, increments on each cycle with dm_ready=0.
  - If it reaches DM_WAIT_MAX with dm_ready still 0, the FSM goes to TRAP with dm_rd/dm_wr deasserted.

## Timing
- Reset: while rst=0, state=S_RST and every output is 0, including trap. The first FETCH occurs one clock after rst deasserts.
- Cycles per instruction (CPI) with zero memory wait:
  - R-type / addi: 4.
  - lw: 5; sw: 4.
  - beq / j / jal: 3.
  - Each dm_ready=0 cycle adds 1.
- trap asserts in the cycle TRAP is entered and stays at 1 until reset.
- An asynchronous reset assertion in any state, including during a memory wait, immediately drops all strobes; no partial write is committed by this block.
- dm_ready=1 outside MEM_RD/MEM_WR is ignored.

## Structure
- Package `mc_pkg` holds:
  - state enum;
  - opcode/funct constants;
  - alu_op, pc_src, reg_dst and wd_sel encodings (shared with the datapath muxes and ALU).
- Sub-module `mc_opdecode`: combinational op/funct → instruction class plus legal flag, and the R-type funct → alu_op map.
- Top level: state register, wait counter, trap flag, and Moore output decode.

## Test plan
- Reset, then an add instruction (op=000000, funct=100000), dm_ready=1: state sequence 0,1,2,3,9,1; rf_wr=1 and reg_dst=01 only in ALU_WB; instr_done pulses once.
- lw (op=100011) with dm_ready low for 2 cycles: MEM_RD lasts 3 cycles with dm_rd=1 throughout, then MEM_WB with wd_sel=01; total 7 cycles.
- beq, twice: with zero=1, BRANCH has pc_wr=1 and pc_src=01; with zero=0, pc_wr=0; both take 3 cycles.
- jal (op=000011): JAL state has pc_wr=1, pc_src=10, rf_wr=1, reg_dst=10, wd_sel=10.
- Illegal opcode 111111, and funct 000111 under R-type: each enters TRAP (state=15) and trap=1, and both persist for 20 cycles.
- Error and mid-operation reset:
  - sw with dm_ready held at 0: TRAP after 15 wait cycles.
  - Separately, assert rst mid-MEM_WR: dm_wr drops to 0 in the same cycle and state=0.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Purpose: shared encodings for the multicycle MIPS control FSM and its datapath.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package mc_pkg;

  // FSM state encodings, also exported on the debug state output
  localparam logic [3:0] S_RST     = 4'd0;
  localparam logic [3:0] S_FETCH   = 4'd1;
  localparam logic [3:0] S_DECODE  = 4'd2;
  localparam logic [3:0] S_EXE_R   = 4'd3;
  localparam logic [3:0] S_EXE_I   = 4'd4;
  localparam logic [3:0] S_MEM_ADR = 4'd5;
  localparam logic [3:0] S_MEM_RD  = 4'd6;
  localparam logic [3:0] S_MEM_WB  = 4'd7;
  localparam logic [3:0] S_MEM_WR  = 4'd8;
  localparam logic [3:0] S_ALU_WB  = 4'd9;
  localparam logic [3:0] S_BRANCH  = 4'd10;
  localparam logic [3:0] S_JUMP    = 4'd11;
  localparam logic [3:0] S_JAL     = 4'd12;
  localparam logic [3:0] S_TRAP    = 4'd15;

  // Opcodes (instruction[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  // R-type function codes (instruction[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU operation select
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;

  // PC source mux
  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_BR    = 2'b01;
  localparam logic [1:0] PC_JMP   = 2'b10;

  // Register-file destination mux
  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  // Register-file write-data mux
  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_MDR = 2'b01;
  localparam logic [1:0] WD_PC  = 2'b10;

  // Instruction class latched in DECODE
  typedef enum logic [2:0] {
    CL_R    = 3'd0,
    CL_ADDI = 3'd1,
    CL_LW   = 3'd2,
    CL_SW   = 3'd3,
    CL_BEQ  = 3'd4,
    CL_J    = 3'd5,
    CL_JAL  = 3'd6,
    CL_ILL  = 3'd7
  } iclass_e;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Purpose: control bus between the multicycle FSM and the datapath/memory.
// Latency: n/a (wires only).
// Backpressure: dm_ready from data memory stalls the FSM in its memory states.
interface multicycle_ctrl_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       dm_ready;
  logic       ir_wr;
  logic       pc_wr;
  logic [1:0] pc_src;
  logic       rf_wr;
  logic [1:0] reg_dst;
  logic [1:0] wd_sel;
  logic       alu_srcb;
  logic [2:0] alu_op;
  logic       dm_rd;
  logic       dm_wr;
  logic       instr_done;
  logic       trap;
  logic [3:0] state;

  // Controller side: consumes instruction fields and status, drives controls
  modport master (
    input  op, funct, zero, dm_ready,
    output ir_wr, pc_wr, pc_src, rf_wr, reg_dst, wd_sel, alu_srcb, alu_op,
           dm_rd, dm_wr, instr_done, trap, state
  );

  // Datapath side: supplies instruction fields and status, obeys controls
  modport slave (
    output op, funct, zero, dm_ready,
    input  ir_wr, pc_wr, pc_src, rf_wr, reg_dst, wd_sel, alu_srcb, alu_op,
           dm_rd, dm_wr, instr_done, trap, state
  );
endinterface

// File: rtl/multicycle_ctrl_opdecode.sv
// Purpose: combinational op/funct decode into instruction class, legal flag and R-type ALU op.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module mc_opdecode
  import mc_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output iclass_e    iclass_o,
  output logic       legal_o,
  output logic [2:0] r_aluop_o
);

  // Classify the opcode; an R-type is only legal for the five supported functs
  always_comb begin
    iclass_o  = CL_ILL;
    legal_o   = 1'b0;
    r_aluop_o = ALU_ADD;
    case (op_i)
      OP_RTYPE: begin
        legal_o  = 1'b1;
        iclass_o = CL_R;
        case (funct_i)
          FN_ADD:  r_aluop_o = ALU_ADD;
          FN_SUB:  r_aluop_o = ALU_SUB;
          FN_AND:  r_aluop_o = ALU_AND;
          FN_OR:   r_aluop_o = ALU_OR;
          FN_SLT:  r_aluop_o = ALU_SLT;
          default: begin
            legal_o  = 1'b0;
            iclass_o = CL_ILL;
          end
        endcase
      end
      OP_ADDI: begin iclass_o = CL_ADDI; legal_o = 1'b1; end
      OP_LW:   begin iclass_o = CL_LW;   legal_o = 1'b1; end
      OP_SW:   begin iclass_o = CL_SW;   legal_o = 1'b1; end
      OP_BEQ:  begin iclass_o = CL_BEQ;  legal_o = 1'b1; end
      OP_J:    begin iclass_o = CL_J;    legal_o = 1'b1; end
      OP_JAL:  begin iclass_o = CL_JAL;  legal_o = 1'b1; end
      default: begin iclass_o = CL_ILL;  legal_o = 1'b0; end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Purpose: Moore control FSM sequencing the shared-ALU MIPS datapath (3-5 cycles per instruction).
// Latency: FETCH one clock after reset release; each dm_ready=0 cycle adds one cycle.
// Backpressure: holds dm_rd/dm_wr until dm_ready; traps after DM_WAIT_MAX idle wait cycles.
module multicycle_ctrl
  import mc_pkg::*;
#(
  parameter int unsigned DM_WAIT_MAX = 15
) (
  input logic               clk,
  input logic               rst,
  multicycle_ctrl_if.master bus
);

  // Counter value on the last permitted wait cycle; the next idle cycle would reach the limit
  localparam logic [3:0] WAIT_LAST = 4'(DM_WAIT_MAX - 1);

  logic [3:0] state_q, state_d;
  iclass_e    cls_q, cls_d;
  logic [2:0] aop_q, aop_d;
  logic [3:0] wcnt_q, wcnt_d;
  logic       trap_q, trap_d;

  iclass_e    dec_cls;
  logic       dec_legal;
  logic [2:0] dec_aop;

  mc_opdecode u_dec (
    .op_i      (bus.op),
    .funct_i   (bus.funct),
    .iclass_o  (dec_cls),
    .legal_o   (dec_legal),
    .r_aluop_o (dec_aop)
  );

  // Next-state logic; class and R-type ALU op are captured in DECODE so op/funct may move on
  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    aop_d   = aop_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      S_RST:    state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        cls_d = dec_cls;
        aop_d = dec_aop;
        if (!dec_legal) begin
          state_d = S_TRAP;
        end else begin
          case (dec_cls)
            CL_R:         state_d = S_EXE_R;
            CL_ADDI:      state_d = S_EXE_I;
            CL_LW, CL_SW: state_d = S_MEM_ADR;
            CL_BEQ:       state_d = S_BRANCH;
            CL_J:         state_d = S_JUMP;
            CL_JAL:       state_d = S_JAL;
            default:      state_d = S_TRAP;
          endcase
        end
      end
      S_EXE_R, S_EXE_I: state_d = S_ALU_WB;
      S_MEM_ADR: begin
        wcnt_d  = 4'd0;
        state_d = (cls_q == CL_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD, S_MEM_WR: begin
        if (bus.dm_ready) begin
          state_d = (state_q == S_MEM_RD) ? S_MEM_WB : S_FETCH;
        end else if (wcnt_q == WAIT_LAST) begin
          state_d = S_TRAP;
        end else begin
          wcnt_d = wcnt_q + 4'd1;
        end
      end
      S_MEM_WB, S_ALU_WB, S_BRANCH, S_JUMP, S_JAL: state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_TRAP;
    endcase
    trap_d = trap_q | (state_d == S_TRAP);
  end

  // State, latched decode, wait counter and sticky trap flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_RST;
      cls_q   <= CL_ILL;
      aop_q   <= ALU_ADD;
      wcnt_q  <= 4'd0;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      aop_q   <= aop_d;
      wcnt_q  <= wcnt_d;
      trap_q  <= trap_d;
    end
  end

  // Output decode from the current state (BRANCH/MEM_WR also look at zero/dm_ready)
  always_comb begin
    bus.ir_wr      = 1'b0;
    bus.pc_wr      = 1'b0;
    bus.pc_src     = PC_PLUS4;
    bus.rf_wr      = 1'b0;
    bus.reg_dst    = RD_RT;
    bus.wd_sel     = WD_ALU;
    bus.alu_srcb   = 1'b0;
    bus.alu_op     = ALU_ADD;
    bus.dm_rd      = 1'b0;
    bus.dm_wr      = 1'b0;
    bus.instr_done = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.ir_wr  = 1'b1;
        bus.pc_wr  = 1'b1;
        bus.pc_src = PC_PLUS4;
      end
      S_EXE_R: bus.alu_op = aop_q;
      S_EXE_I, S_MEM_ADR: begin
        bus.alu_srcb = 1'b1;
        bus.alu_op   = ALU_ADD;
      end
      S_MEM_RD: bus.dm_rd = 1'b1;
      S_MEM_WR: begin
        bus.dm_wr      = 1'b1;
        bus.instr_done = bus.dm_ready;
      end
      S_MEM_WB: begin
        bus.rf_wr      = 1'b1;
        bus.reg_dst    = RD_RT;
        bus.wd_sel     = WD_MDR;
        bus.instr_done = 1'b1;
      end
      S_ALU_WB: begin
        bus.rf_wr      = 1'b1;
        bus.wd_sel     = WD_ALU;
        bus.reg_dst    = (cls_q == CL_R) ? RD_RD : RD_RT;
        bus.instr_done = 1'b1;
      end
      S_BRANCH: begin
        bus.alu_op     = ALU_SUB;
        bus.pc_wr      = bus.zero;
        bus.pc_src     = PC_BR;
        bus.instr_done = 1'b1;
      end
      S_JUMP: begin
        bus.pc_wr      = 1'b1;
        bus.pc_src     = PC_JMP;
        bus.instr_done = 1'b1;
      end
      S_JAL: begin
        // PC was already advanced in FETCH, so WD_PC writes the return address
        bus.pc_wr      = 1'b1;
        bus.pc_src     = PC_JMP;
        bus.rf_wr      = 1'b1;
        bus.reg_dst    = RD_RA;
        bus.wd_sel     = WD_PC;
        bus.instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.trap  = trap_q;
  assign bus.state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Purpose: directed, table-driven bench for the multicycle control FSM.
// Latency: samples outputs 1 time unit after each rising clock edge.
// Backpressure: dm_ready driven per vector / hand-written sequence.
module tb_multicycle_ctrl;
  import mc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.DM_WAIT_MAX(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [5:0]       op;
    logic [5:0]       funct;
    logic             zero;
    int               len;
    logic [4:0][3:0]  seq;
    logic [4:0][15:0] ctl;
  } vec_t;

  vec_t vecs [12];

  // Packs the control outputs in a fixed order for compact expected values
  function automatic logic [15:0] cw(input logic ir, input logic pcw, input logic [1:0] pcs,
                                     input logic rf, input logic [1:0] rd, input logic [1:0] wd,
                                     input logic srcb, input logic [2:0] aop,
                                     input logic drd, input logic dwr, input logic done);
    return {ir, pcw, pcs, rf, rd, wd, srcb, aop, drd, dwr, done};
  endfunction

  function automatic logic [15:0] cur_cw();
    return {bus.ir_wr, bus.pc_wr, bus.pc_src, bus.rf_wr, bus.reg_dst, bus.wd_sel,
            bus.alu_srcb, bus.alu_op, bus.dm_rd, bus.dm_wr, bus.instr_done};
  endfunction

  function automatic vec_t mk(input logic [5:0] op, input logic [5:0] fn, input logic z, input int len,
                              input logic [3:0] s0, input logic [3:0] s1, input logic [3:0] s2,
                              input logic [3:0] s3, input logic [3:0] s4,
                              input logic [15:0] c0, input logic [15:0] c1, input logic [15:0] c2,
                              input logic [15:0] c3, input logic [15:0] c4);
    vec_t v;
    v.op = op; v.funct = fn; v.zero = z; v.len = len;
    v.seq[0] = s0; v.seq[1] = s1; v.seq[2] = s2; v.seq[3] = s3; v.seq[4] = s4;
    v.ctl[0] = c0; v.ctl[1] = c1; v.ctl[2] = c2; v.ctl[3] = c3; v.ctl[4] = c4;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Holds reset for two clocks checking the idle outputs, then releases it and expects FETCH
  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst state async", 32'(bus.state), 32'(S_RST));
    step();
    step();
    chk("rst state", 32'(bus.state), 32'(S_RST));
    chk("rst ctl", 32'(cur_cw()), 32'h0);
    chk("rst trap", 32'(bus.trap), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    step();
    chk("first fetch", 32'(bus.state), 32'(S_FETCH));
  endtask

  task automatic run_trap(input string name, input logic [5:0] op, input logic [5:0] fn);
    bus.op = op; bus.funct = fn;
    step();
    chk({name, " decode"}, 32'(bus.state), 32'(S_DECODE));
    step();
    chk({name, " state"}, 32'(bus.state), 32'(S_TRAP));
    chk({name, " trap"}, 32'(bus.trap), 32'h1);
    chk({name, " ctl"}, 32'(cur_cw()), 32'h0);
    for (int c = 0; c < 20; c++) begin
      step();
      chk({name, " hold state"}, 32'(bus.state), 32'(S_TRAP));
      chk({name, " hold trap"}, 32'(bus.trap), 32'h1);
    end
  endtask

  initial begin
    logic [15:0] F, Z;
    int ndone, cyc;
    F = cw(1, 1, 2'b00, 0, 2'b00, 2'b00, 0, 3'd0, 0, 0, 0);
    Z = 16'h0;

    //          op     funct  z len  states               controls per state
    vecs[0]  = mk(6'h00, 6'h20, 0, 4, 1, 2, 3, 9, 0, F, Z, Z,
                  cw(0, 0, 2'b00, 1, 2'b01, 2'b00, 0, 3'd0, 0, 0, 1), Z);
    vecs[1]  = mk(6'h00, 6'h22, 0, 4, 1, 2, 3, 9, 0, F, Z,
                  cw(0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 3'd1, 0, 0, 0),
                  cw(0, 0, 2'b00, 1, 2'b01, 2'b00, 0, 3'd0, 0, 0, 1), Z);
    vecs[2]  = mk(6'h00, 6'h24, 0, 4, 1, 2, 3, 9, 0, F, Z,
                  cw(0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 3'd2, 0, 0, 0),
                  cw(0, 0, 2'b00, 1, 2'b01, 2'b00, 0, 3'd0, 0, 0, 1), Z);
    vecs[3]  = mk(6'h00, 6'h25, 0, 4, 1, 2, 3, 9, 0, F, Z,
                  cw(0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 3'd3, 0, 0, 0),
                  cw(0, 0, 2'b00, 1, 2'b01, 2'b00, 0, 3'd0, 0, 0, 1), Z);
    vecs[4]  = mk(6'h00, 6'h2A, 0, 4, 1, 2, 3, 9, 0, F, Z,
                  cw(0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 3'd4, 0, 0, 0),
                  cw(0, 0, 2'b00, 1, 2'b01, 2'b00, 0, 3'd0, 0, 0, 1), Z);
    vecs[5]  = mk(6'h08, 6'h3F, 0, 4, 1, 2, 4, 9, 0, F, Z,
                  cw(0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 3'd0, 0, 0, 0),
                  cw(0, 0, 2'b00, 1, 2'b00, 2'b00, 0, 3'd0, 0, 0, 1), Z);
    vecs[6]  = mk(6'h23, 6'h00, 0, 5, 1, 2, 5, 6, 7, F, Z,
                  cw(0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 3'd0, 0, 0, 0),
                  cw(0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 3'd0, 1, 0, 0),
                  cw(0, 0, 2'b00, 1, 2'b00, 2'b01, 0, 3'd0, 0, 0, 1));
    vecs[7]  = mk(6'h2B, 6'h00, 0, 4, 1, 2, 5, 8, 0, F, Z,
                  cw(0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 3'd0, 0, 0, 0),
                  cw(0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 3'd0, 0, 1, 1), Z);
    vecs[8]  = mk(6'h04, 6'h00, 1, 3, 1, 2, 10, 0, 0, F, Z,
                  cw(0, 1, 2'b01, 0, 2'b00, 2'b00, 0, 3'd1, 0, 0, 1), Z, Z);
    vecs[9]  = mk(6'h04, 6'h00, 0, 3, 1, 2, 10, 0, 0, F, Z,
                  cw(0, 0, 2'b01, 0, 2'b00, 2'b00, 0, 3'd1, 0, 0, 1), Z, Z);
    vecs[10] = mk(6'h02, 6'h00, 0, 3, 1, 2, 11, 0, 0, F, Z,
                  cw(0, 1, 2'b10, 0, 2'b00, 2'b00, 0, 3'd0, 0, 0, 1), Z, Z);
    vecs[11] = mk(6'h03, 6'h00, 0, 3, 1, 2, 12, 0, 0, F, Z,
                  cw(0, 1, 2'b10, 1, 2'b10, 2'b10, 0, 3'd0, 0, 0, 1), Z, Z);

    bus.op = 6'h00; bus.funct = 6'h00; bus.zero = 1'b0; bus.dm_ready = 1'b1;
    #2;
    do_reset();

    // Table: one instruction per record, op/funct scrambled once the class is latched
    for (int i = 0; i < 12; i++) begin
      bus.op = vecs[i].op; bus.funct = vecs[i].funct; bus.zero = vecs[i].zero;
      bus.dm_ready = 1'b1;
      ndone = 0;
      for (int k = 0; k < vecs[i].len; k++) begin
        if (k == 2) begin
          bus.op = 6'h3F; bus.funct = 6'h3F;
        end
        chk($sformatf("v%0d state c%0d", i, k), 32'(bus.state), 32'(vecs[i].seq[k]));
        chk($sformatf("v%0d ctl c%0d", i, k), 32'(cur_cw()), 32'(vecs[i].ctl[k]));
        if (bus.instr_done) ndone++;
        step();
      end
      chk($sformatf("v%0d back to fetch", i), 32'(bus.state), 32'(S_FETCH));
      chk($sformatf("v%0d done pulses", i), 32'(ndone), 32'd1);
      chk($sformatf("v%0d trap", i), 32'(bus.trap), 32'h0);
    end

    // lw with two dm_ready=0 cycles; dm_ready=1 outside memory states must be ignored
    bus.op = OP_LW; bus.funct = 6'h00; bus.dm_ready = 1'b1;
    cyc = 0;
    chk("lw fetch", 32'(bus.state), 32'(S_FETCH));
    step(); cyc++;
    chk("lw decode", 32'(bus.state), 32'(S_DECODE));
    step(); cyc++;
    chk("lw adr", 32'(bus.state), 32'(S_MEM_ADR));
    bus.dm_ready = 1'b0;
    step(); cyc++;
    for (int w = 0; w < 3; w++) begin
      if (w == 2) bus.dm_ready = 1'b1;
      chk($sformatf("lw memrd state w%0d", w), 32'(bus.state), 32'(S_MEM_RD));
      chk($sformatf("lw dm_rd w%0d", w), 32'(bus.dm_rd), 32'h1);
      chk($sformatf("lw done w%0d", w), 32'(bus.instr_done), 32'h0);
      step(); cyc++;
    end
    chk("lw memwb state", 32'(bus.state), 32'(S_MEM_WB));
    chk("lw wd_sel", 32'(bus.wd_sel), 32'(WD_MDR));
    chk("lw rf_wr", 32'(bus.rf_wr), 32'h1);
    chk("lw done", 32'(bus.instr_done), 32'h1);
    step(); cyc++;
    chk("lw refetch", 32'(bus.state), 32'(S_FETCH));
    chk("lw cycles", 32'(cyc), 32'd7);

    // Illegal opcode, then illegal R-type funct
    run_trap("ill op", 6'b111111, 6'h20);
    do_reset();
    run_trap("ill funct", OP_RTYPE, 6'b000111);
    do_reset();

    // sw with dm_ready stuck low: 15 wait cycles then TRAP with strobes dropped
    bus.op = OP_SW; bus.dm_ready = 1'b0;
    step();
    step();
    chk("sw to adr", 32'(bus.state), 32'(S_MEM_ADR));
    step();
    for (int w = 0; w < 15; w++) begin
      chk($sformatf("sw wait state w%0d", w), 32'(bus.state), 32'(S_MEM_WR));
      chk($sformatf("sw wait dm_wr w%0d", w), 32'(bus.dm_wr), 32'h1);
      chk($sformatf("sw wait trap w%0d", w), 32'(bus.trap), 32'h0);
      step();
    end
    chk("sw timeout state", 32'(bus.state), 32'(S_TRAP));
    chk("sw timeout dm_wr", 32'(bus.dm_wr), 32'h0);
    chk("sw timeout trap", 32'(bus.trap), 32'h1);
    do_reset();

    // Reset asserted in the middle of a MEM_WR wait drops dm_wr immediately
    bus.op = OP_SW; bus.dm_ready = 1'b0;
    step(); step(); step();
    chk("midrst in memwr", 32'(bus.state), 32'(S_MEM_WR));
    step();
    chk("midrst dm_wr before", 32'(bus.dm_wr), 32'h1);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst dm_wr", 32'(bus.dm_wr), 32'h0);
    chk("midrst state", 32'(bus.state), 32'(S_RST));
    chk("midrst instr_done", 32'(bus.instr_done), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    step();
    chk("midrst refetch", 32'(bus.state), 32'(S_FETCH));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
